dep_check_q: RTL and testbench
==============================

DEP_CHECK_Q -- requirements
Module: dep_check_q

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data and check-value width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of 2, minimum 2.
REQ-003 SHALL have parameter NUM_CHK, default 3: number of dependency-check channels, minimum 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset; asynchronous assert, active-low.
REQ-006 SHALL have port chk_data_i, input, NUM_CHK*WIDTH: packed check values; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port chk_vld_i, input, NUM_CHK: per-channel enable; a channel whose bit is 0 never matches.
REQ-008 SHALL have port data_i, input, WIDTH: push data.
REQ-009 SHALL have port valid_i, input, 1: push request.
REQ-010 SHALL have port ready_o, output, 1: queue can accept a push.
REQ-011 SHALL have port data_o, output, WIDTH: head entry.
REQ-012 SHALL have port valid_o, output, 1: head entry is present and has no dependency.
REQ-013 SHALL have port ready_i, input, 1: consumer accepts head.
REQ-014 SHALL have port dep_o, output, 1: head entry matches at least one enabled check channel.
REQ-015 SHALL have port flush_i, input, 1: synchronous queue clear.
REQ-016 SHALL have port count_o, output, $clog2(DEPTH)+1: current occupancy.
REQ-017 SHALL have port stall_cnt_o, output, 16: saturating count of dependency-stall cycles.
REQ-018 SHALL have port stall_clr_i, input, 1: synchronous clear of stall_cnt_o.

Function
REQ-019 SHALL implement an in-order circular FIFO of DEPTH entries with read/write pointers that wrap from DEPTH-1 to 0.
REQ-020 SHALL set ready_o = (count_o < DEPTH); a push is accepted only while the queue is not full.
REQ-021 SHALL perform a push when valid_i & ready_o: data_i is written at the write pointer and that pointer advances.
REQ-022 SHALL perform a pop when valid_o & ready_i: the read pointer advances.
REQ-023 SHALL, on a simultaneous push and pop, leave count_o unchanged and advance both pointers.
REQ-024 SHALL have a latency of one cycle: data pushed into an empty queue appears on data_o and is eligible for valid_o in the next cycle; no combinational path from data_i to data_o.
REQ-025 SHALL compute dep_o combinationally as: queue non-empty AND, for any k, (chk_vld_i[k] AND chk_data_i channel k equal to the head entry); dep_o = 0 when empty.
REQ-026 SHALL drive valid_o = non-empty & ~dep_o; the head is held, and not popped, while dep_o = 1 regardless of ready_i.
REQ-027 SHALL drive data_o = head entry when non-empty and 0 when empty.
REQ-028 SHALL check only the head entry; entries behind the head are not checked.
REQ-029 SHALL, when flush_i = 1, reset both pointers and count_o to 0 at the next edge; flush overrides any push or pop in the same cycle, and entry contents need not be cleared.
REQ-030 SHALL increment stall_cnt_o on each cycle in which dep_o = 1, saturating at 16'hFFFF.
REQ-031 SHALL set stall_cnt_o to 0 when stall_clr_i = 1; clear has priority over increment.
REQ-032 SHALL leave stall_cnt_o unaffected by flush_i.

Reset
REQ-033 SHALL, while rst_n = 0, immediately and asynchronously clear pointers, count_o and stall_cnt_o to 0.
REQ-034 SHALL therefore, during reset, drive ready_o = 1, valid_o = 0, dep_o = 0 and data_o = 0; storage contents need no reset.
REQ-035 SHALL, on reset assertion mid-operation, discard all queued entries; the first push after deassertion is treated as entering an empty queue.

Verification
REQ-036 Fill/drain (defaults, chk_vld_i = 0): push 0x11, 0x22, 0x33, 0x44 back-to-back.
- Expect ready_o = 0 after the 4th push, count_o = 4.
- Then hold ready_i = 1: expect data_o to output 0x11..0x44 in order on consecutive cycles, then count_o = 0.

REQ-037 Dependency stall: queue holds 0x55; set channel 1 = 0x55 with chk_vld_i = 3'b010 for 5 cycles, ready_i = 1.
- Expect dep_o = 1, valid_o = 0 and stall_cnt_o to increase by 5.
- Then set chk_vld_i = 0: expect valid_o = 1 and 0x55 popped on that edge.

REQ-038 Disabled match: channel 0 = head value with chk_vld_i[0] = 0 -> expect dep_o = 0 and valid_o = 1.

REQ-039 Simultaneous push/pop while count = 2, plus wrap: run 10 such cycles with DEPTH = 4.
- Expect count_o to stay at 2 throughout.
- Expect output order to equal input order across pointer wrap.

REQ-040 Flush precedence: count = 3, assert flush_i with valid_i = 1 and ready_i = 1 -> expect count_o = 0, valid_o = 0 and ready_o = 1 on the next cycle.

REQ-041 Async reset mid-stream and saturation:
- Drop rst_n between edges with count = 2: expect count_o = 0 and valid_o = 0 before the next edge.
- Force 65,540 stall cycles: expect stall_cnt_o = 16'hFFFF.
- Assert stall_clr_i on a stall cycle: expect stall_cnt_o = 0 after that edge.

Source files
------------

// File: rtl/dep_check_q.sv
// In-order FIFO whose head entry is held back while it matches any enabled
// dependency-check channel; also counts the cycles spent stalled that way.
module dep_check_q #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 4,
  parameter int NUM_CHK = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CHK*WIDTH-1:0]   chk_data_i,
  input  logic [NUM_CHK-1:0]         chk_vld_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       dep_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [15:0]                stall_cnt_o,
  input  logic                       stall_clr_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [15:0]      stall_q,  stall_d;

  logic             empty;
  logic             match;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_CHK; k++) begin
      if (chk_vld_i[k] && (chk_data_i[k*WIDTH +: WIDTH] == head)) match = 1'b1;
    end
  end

  assign dep_o   = ~empty & match;
  assign valid_o = ~empty & ~dep_o;
  assign data_o  = empty ? '0 : head;
  assign ready_o = (count_q < FULL_CNT);
  assign count_o = count_q;
  assign stall_cnt_o = stall_q;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH-1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_clr_i)                     stall_d = '0;
    else if (dep_o && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // NOTE: storage has no reset; count_q gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: tb/tb_dep_check_q.sv
// Directed bench for dep_check_q: a queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_dep_check_q;

  localparam int WIDTH   = 64;
  localparam int DEPTH   = 4;
  localparam int NUM_CHK = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CHK*WIDTH-1:0] chk_data_i;
  logic [NUM_CHK-1:0]       chk_vld_i;
  logic [WIDTH-1:0]         data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [WIDTH-1:0]         data_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     dep_o;
  logic                     flush_i;
  logic [$clog2(DEPTH):0]   count_o;
  logic [15:0]              stall_cnt_o;
  logic                     stall_clr_i;

  int n_chk  = 0;
  int n_fail = 0;

  dep_check_q #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CHK(NUM_CHK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chk_data_i  (chk_data_i),
    .chk_vld_i   (chk_vld_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .dep_o       (dep_o),
    .flush_i     (flush_i),
    .count_o     (count_o),
    .stall_cnt_o (stall_cnt_o),
    .stall_clr_i (stall_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents and stall count as plain data.
  logic [WIDTH-1:0] m_q[$];
  int               m_stall = 0;

  function automatic bit model_dep();
    if (m_q.size() == 0) return 1'b0;
    for (int k = 0; k < NUM_CHK; k++)
      if (chk_vld_i[k] && chk_data_i[k*WIDTH +: WIDTH] == m_q[0]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_stall = 0;
      end else begin
        bit d, v, pu, po;
        d  = model_dep();
        v  = (m_q.size() > 0) && !d;
        pu = valid_i && (m_q.size() < DEPTH);
        po = v && ready_i;
        if (stall_clr_i)             m_stall = 0;
        else if (d && m_stall < 65535) m_stall++;
        if (flush_i) m_q.delete();
        else begin
          if (po) void'(m_q.pop_front());
          if (pu) m_q.push_back(data_i);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_count", 64'(count_o), 64'(m_q.size()));
      check("cyc_ready", 64'(ready_o), 64'(m_q.size() < DEPTH));
      check("cyc_dep",   64'(dep_o),   64'(model_dep()));
      check("cyc_valid", 64'(valid_o), 64'((m_q.size() > 0) && !model_dep()));
      check("cyc_data",  data_o, (m_q.size() > 0) ? m_q[0] : 64'h0);
      check("cyc_stall", 64'(stall_cnt_o), 64'(m_stall));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_chk(input int k, input logic [WIDTH-1:0] v);
    chk_data_i[k*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    rst_n = 1'b0; chk_data_i = '0; chk_vld_i = '0; data_i = '0; valid_i = 1'b0;
    ready_i = 1'b0; flush_i = 1'b0; stall_clr_i = 1'b0;
    #12;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_dep",   64'(dep_o),   64'd0);
    check("rst_data",  data_o,       64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_stall", 64'(stall_cnt_o), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    step();

    // Fill to full, then drain in order.
    valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_i = 64'(i * 'h11);
      step();
    end
    valid_i = 1'b0;
    check("fill_count", 64'(count_o), 64'd4);
    check("fill_ready", 64'(ready_o), 64'd0);
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data",  data_o, 64'(i * 'h11));
      check("drain_valid", 64'(valid_o), 64'd1);
      step();
    end
    ready_i = 1'b0;
    check("drain_count", 64'(count_o), 64'd0);

    // Dependency stall on channel 1 for five cycles.
    valid_i = 1'b1; data_i = 64'h55; step(); valid_i = 1'b0;
    check("stall_start", 64'(stall_cnt_o), 64'd0);
    set_chk(1, 64'h55); chk_vld_i = 3'b010; ready_i = 1'b1;
    #1;
    check("stall_dep",   64'(dep_o),   64'd1);
    check("stall_valid", 64'(valid_o), 64'd0);
    repeat (5) step();
    check("stall_cnt5",  64'(stall_cnt_o), 64'd5);
    check("stall_held",  64'(count_o), 64'd1);
    chk_vld_i = 3'b000;
    #1;
    check("release_valid", 64'(valid_o), 64'd1);
    check("release_data",  data_o, 64'h55);
    step();
    check("release_pop",  64'(count_o), 64'd0);
    check("release_stall", 64'(stall_cnt_o), 64'd5);
    ready_i = 1'b0;

    // A matching but disabled channel does not stall.
    valid_i = 1'b1; data_i = 64'hAA; step(); valid_i = 1'b0;
    set_chk(0, 64'hAA); chk_vld_i = 3'b110;
    #1;
    check("dis_dep",   64'(dep_o),   64'd0);
    check("dis_valid", 64'(valid_o), 64'd1);
    ready_i = 1'b1; step(); ready_i = 1'b0; chk_vld_i = 3'b000;

    // Steady push+pop at count 2 across pointer wrap.
    valid_i = 1'b1;
    data_i = 64'h100; step();
    data_i = 64'h101; step();
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_i = 64'(64'h102 + i);
      check("pp_count", 64'(count_o), 64'd2);
      check("pp_data",  data_o, 64'(64'h100 + i));
      step();
    end
    valid_i = 1'b0;
    check("pp_tail0", data_o, 64'h10A); step();
    check("pp_tail1", data_o, 64'h10B); step();
    check("pp_empty", 64'(count_o), 64'd0);
    ready_i = 1'b0;

    // Flush beats a simultaneous push and pop.
    valid_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin data_i = 64'(64'h200 + i); step(); end
    check("fl_count3", 64'(count_o), 64'd3);
    flush_i = 1'b1; ready_i = 1'b1; data_i = 64'h2FF;
    step();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    check("fl_count", 64'(count_o), 64'd0);
    check("fl_valid", 64'(valid_o), 64'd0);
    check("fl_ready", 64'(ready_o), 64'd1);

    // Asynchronous reset between edges discards queued entries.
    valid_i = 1'b1;
    data_i = 64'h301; step();
    data_i = 64'h302; step();
    valid_i = 1'b0;
    check("ar_count2", 64'(count_o), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("ar_count", 64'(count_o), 64'd0);
    check("ar_valid", 64'(valid_o), 64'd0);
    check("ar_ready", 64'(ready_o), 64'd1);
    @(negedge clk); #1 rst_n = 1'b1;
    valid_i = 1'b1; data_i = 64'h300; step(); valid_i = 1'b0;
    check("ar_first_data",  data_o, 64'h300);
    check("ar_first_count", 64'(count_o), 64'd1);

    // Saturation, clear priority, and flush leaving the counter alone.
    set_chk(2, 64'h300); chk_vld_i = 3'b100; ready_i = 1'b1;
    repeat (65540) step();
    check("sat_stall", 64'(stall_cnt_o), 64'hFFFF);
    stall_clr_i = 1'b1; step(); stall_clr_i = 1'b0;
    check("clr_stall", 64'(stall_cnt_o), 64'd0);
    step();
    check("clr_resume", 64'(stall_cnt_o), 64'd1);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("flush_keep_stall", 64'(stall_cnt_o), 64'd2);
    check("flush_empty",      64'(count_o), 64'd0);
    chk_vld_i = 3'b000; ready_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
